// File: rtl/boundary_fifo_arbiter.sv
// boundary_fifo_arbiter: round-robin merge of the boundary-PU message FIFOs
// of one decoder half onto the single inter-FPGA link. Each granted message
// is tagged with its source FIFO index: out_data = {index, message}.
// Optional statistics counters are enabled by defining BOUNDARY_ARB_STATS_EN.
module boundary_fifo_arbiter #(
    parameter int FIFO_COUNT = 20,
    parameter int MSG_WIDTH  = 20,
    parameter int IDX_WIDTH  = $clog2(FIFO_COUNT)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              new_round_start,
    input  logic [FIFO_COUNT*MSG_WIDTH-1:0]   in_data,
    input  logic [FIFO_COUNT-1:0]             in_valid,
    output logic [FIFO_COUNT-1:0]             in_ready,
    output logic [IDX_WIDTH+MSG_WIDTH-1:0]    out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
`ifdef BOUNDARY_ARB_STATS_EN
    output logic [31:0]                       grant_count,
    output logic [31:0]                       stall_cycles,
`endif
    output logic                              busy
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(FIFO_COUNT - 1);
    localparam logic [IDX_WIDTH:0]   COUNT_W  = (IDX_WIDTH+1)'(FIFO_COUNT);

    logic [IDX_WIDTH-1:0] last_grant;
    logic [IDX_WIDTH-1:0] start_idx;
    logic [IDX_WIDTH-1:0] grant_idx;
    logic [IDX_WIDTH:0]   cand;
    logic                 grant_found;
    logic                 loadable;
    logic                 accept;
    logic [MSG_WIDTH-1:0] grant_msg;

    // Search starts just past the previous winner; wraps at FIFO_COUNT, not 2^IDX_WIDTH.
    assign start_idx = (last_grant == LAST_IDX) ? '0 : last_grant + 1'b1;

    // First valid FIFO at or after start_idx, modulo FIFO_COUNT.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < FIFO_COUNT; k++) begin
            cand = {1'b0, start_idx} + (IDX_WIDTH+1)'(k);
            if (cand >= COUNT_W)
                cand = cand - COUNT_W;
            if (!grant_found && in_valid[cand[IDX_WIDTH-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDX_WIDTH-1:0];
            end
        end
    end

    assign grant_msg = in_data[grant_idx*MSG_WIDTH +: MSG_WIDTH];
    assign loadable  = !out_valid || out_ready;
    // A flush cycle never accepts input, so nothing is lost when the register is cleared.
    assign accept    = loadable && grant_found && !new_round_start && !reset;

    // One-hot ready towards the granted FIFO only.
    always_comb begin
        in_ready = '0;
        if (accept)
            in_ready[grant_idx] = 1'b1;
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            last_grant <= LAST_IDX;
        end else if (new_round_start) begin
            out_valid  <= 1'b0;
            last_grant <= LAST_IDX;
        end else if (loadable) begin
            if (grant_found) begin
                out_valid  <= 1'b1;
                out_data   <= {grant_idx, grant_msg};
                last_grant <= grant_idx;
            end else begin
                out_valid  <= 1'b0;
            end
        end
    end

    assign busy = out_valid || (|in_valid);

`ifdef BOUNDARY_ARB_STATS_EN
    // Link transfer and link stall counters, cleared at each decoding round.
    always_ff @(posedge clk) begin
        if (reset || new_round_start) begin
            grant_count  <= '0;
            stall_cycles <= '0;
        end else begin
            if (out_valid && out_ready)
                grant_count <= grant_count + 32'd1;
            if (out_valid && !out_ready)
                stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_boundary_fifo_arbiter.sv
// tb_boundary_fifo_arbiter: directed and randomized checks of
// boundary_fifo_arbiter against a transaction-level reference model.
// Define BOUNDARY_ARB_STATS_EN to also check the statistics counters.
module tb_boundary_fifo_arbiter;

    localparam int F  = 20;
    localparam int MW = 20;
    localparam int IW = 5;
    localparam logic [F-1:0] ALL = '1;

    logic              clk = 1'b0;
    logic              reset;
    logic              new_round_start;
    logic [F*MW-1:0]   in_data;
    logic [F-1:0]      in_valid;
    logic [F-1:0]      in_ready;
    logic [IW+MW-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
`ifdef BOUNDARY_ARB_STATS_EN
    logic [31:0]       grant_count;
    logic [31:0]       stall_cycles;
`endif

    boundary_fifo_arbiter #(.FIFO_COUNT(F), .MSG_WIDTH(MW), .IDX_WIDTH(IW)) dut (
        .clk(clk),
        .reset(reset),
        .new_round_start(new_round_start),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
`ifdef BOUNDARY_ARB_STATS_EN
        .grant_count(grant_count),
        .stall_cycles(stall_cycles),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state: what the link register should hold.
    bit               m_ov;
    logic [IW+MW-1:0] m_od;
    int               m_lg;
    int unsigned      m_gc;
    int unsigned      m_sc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Round robin: first valid index strictly after lg, modulo F; -1 if none.
    function automatic int pick(input logic [F-1:0] v, input int lg);
        for (int k = 1; k <= F; k++)
            if (v[(lg + k) % F]) return (lg + k) % F;
        return -1;
    endfunction

    // One clock: apply inputs, check combinational and registered outputs, advance model.
    task automatic cyc(input bit r, input bit nrs, input logic [F-1:0] v, input bit rdy);
        int               j;
        bit               ld;
        logic [F-1:0]     exp_rdy;
        logic [MW-1:0]    msg;
        reset           = r;
        new_round_start = nrs;
        in_valid        = v;
        out_ready       = rdy;
        for (int i = 0; i < F; i++) in_data[i*MW +: MW] = MW'($urandom);
        @(negedge clk);
        j  = pick(v, m_lg);
        ld = !m_ov || rdy;
        exp_rdy = '0;
        if (!r && !nrs && ld && j >= 0) exp_rdy[j] = 1'b1;
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        chk("busy", 64'(busy), 64'(m_ov || (v != 0)));
        chk("out_valid", 64'(out_valid), 64'(m_ov));
        chk("out_data", 64'(out_data), 64'(m_od));
`ifdef BOUNDARY_ARB_STATS_EN
        chk("grant_count", 64'(grant_count), 64'(m_gc));
        chk("stall_cycles", 64'(stall_cycles), 64'(m_sc));
`endif
        if (r) begin
            m_ov = 0; m_od = '0; m_lg = F - 1; m_gc = 0; m_sc = 0;
        end else if (nrs) begin
            m_ov = 0; m_lg = F - 1; m_gc = 0; m_sc = 0;
        end else begin
            if (m_ov && rdy)  m_gc++;
            if (m_ov && !rdy) m_sc++;
            if (ld) begin
                if (j >= 0) begin
                    msg  = in_data[j*MW +: MW];
                    m_ov = 1;
                    m_od = {IW'(j), msg};
                    m_lg = j;
                end else begin
                    m_ov = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic int out_idx();
        return int'(out_data[IW+MW-1:MW]);
    endfunction

    initial begin
        logic [F-1:0] v;
        logic [F-1:0] pair;
        logic [F-1:0] one;
        m_ov = 0; m_od = '0; m_lg = F - 1; m_gc = 0; m_sc = 0;
        reset = 1; new_round_start = 0; in_valid = '0; out_ready = 0; in_data = '0;
        @(posedge clk); #1;
        // Reset with random valids: no ready, busy follows in_valid.
        for (int c = 0; c < 3; c++) cyc(1, 0, F'($urandom), 1'($urandom));

        // All valid, link always ready: strict index sequence, one per cycle.
        for (int c = 0; c < 40; c++) begin
            cyc(0, 0, ALL, 1);
            chk("rr_seq", 64'(out_idx()), 64'(c % F));
        end

        // Only FIFOs 3 and 17 contend.
        pair = '0; pair[3] = 1'b1; pair[17] = 1'b1;
        cyc(0, 1, ALL, 1);
        for (int c = 0; c < 8; c++) begin
            cyc(0, 0, pair, 1);
            chk("pair_seq", 64'(out_idx()), (c % 2 == 0) ? 64'd3 : 64'd17);
        end

        // Backpressure holding index 5.
        cyc(0, 1, ALL, 1);
        for (int c = 0; c < 6; c++) cyc(0, 0, ALL, 1);
        chk("bp_load", 64'(out_idx()), 64'd5);
        for (int c = 0; c < 4; c++) begin
            cyc(0, 0, ALL, 0);
            chk("bp_hold", 64'(out_idx()), 64'd5);
        end
        cyc(0, 0, ALL, 1);
        chk("bp_next", 64'(out_idx()), 64'd6);

        // Flush with last_grant = 12 and a message in the register.
        cyc(0, 1, ALL, 1);
        for (int c = 0; c < 13; c++) cyc(0, 0, ALL, 1);
        chk("fl_pre", 64'(out_idx()), 64'd12);
        cyc(0, 1, ALL, 1);
        chk("fl_empty", 64'(out_valid), 64'd0);
        cyc(0, 0, ALL, 1);
        chk("fl_first", 64'(out_idx()), 64'd0);

        // Wrap from 19 back to 0.
        one = '0; one[19] = 1'b1;
        cyc(0, 0, one, 1);
        chk("wrap_19", 64'(out_idx()), 64'd19);
        one = '0; one[0] = 1'b1;
        cyc(0, 0, one, 1);
        chk("wrap_0", 64'(out_idx()), 64'd0);

        // busy: idle, then a single FIFO 7 pulse held at the link.
        cyc(0, 0, '0, 1);
        cyc(0, 0, '0, 1);
        chk("busy_idle", 64'(busy), 64'd0);
        one = '0; one[7] = 1'b1;
        cyc(0, 0, one, 0);
        for (int c = 0; c < 3; c++) begin
            cyc(0, 0, '0, 0);
            chk("busy_held", 64'(busy), 64'd1);
        end
        cyc(0, 0, '0, 1);
        chk("busy_done", 64'(busy), 64'd0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            case ($urandom_range(0, 3))
                0:       v = F'($urandom) & F'($urandom) & F'($urandom);
                1:       v = F'($urandom);
                2:       v = ALL;
                default: v = '0;
            endcase
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0, v,
                $urandom_range(0, 3) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
